// File: rtl/mlp_folded_engine_if.sv
// rtl/mlp_folded_engine_if.sv - start/result and weight-write bus of the folded MLP engine
interface mlp_folded_engine_if #(
    parameter int N     = 5,
    parameter int M     = 3,
    parameter int WIDTH = 8
);
    localparam int LW = (M > 1) ? $clog2(M) : 1;
    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = $clog2(N + 1);

    logic                        soc;
    logic [N-1:0][WIDTH-1:0]     in;
    logic                        w_we;
    logic [LW-1:0]               w_layer;
    logic [NW-1:0]               w_neuron;
    logic [IW-1:0]               w_idx;
    logic [WIDTH-1:0]            w_data;
    logic [N-1:0][WIDTH-1:0]     out;
    logic                        eoc;
    logic                        busy;

    modport master (
        output soc, in, w_we, w_layer, w_neuron, w_idx, w_data,
        input  out, eoc, busy
    );

    modport slave (
        input  soc, in, w_we, w_layer, w_neuron, w_idx, w_data,
        output out, eoc, busy
    );
endinterface

// File: rtl/mlp_folded_engine.sv
// rtl/mlp_folded_engine.sv - M-layer x N-neuron fixed-point MLP with N MAC lanes folded over N+1 terms
module mlp_folded_engine #(
    parameter int N       = 5,
    parameter int M       = 3,
    parameter int WIDTH   = 8,
    parameter int FRAC    = 4,
    parameter int OUT_ACT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mlp_folded_engine_if.slave   bus
);
    localparam int LW    = (M > 1) ? $clog2(M) : 1;
    localparam int NW    = (N > 1) ? $clog2(N) : 1;
    localparam int IW    = $clog2(N + 1);
    localparam int ACC_W = 2 * WIDTH + $clog2(N + 1);

    localparam logic [LW-1:0] LAST_LAYER = LW'(M - 1);
    localparam logic [NW-1:0] LAST_NEUR  = NW'(N - 1);
    localparam logic [IW-1:0] K_BIAS     = IW'(N);

    localparam logic signed [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] MAX_A = ACC_W'(MAX_W);
    localparam logic signed [ACC_W-1:0] MIN_A = ACC_W'(MIN_W);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_DONE} state_t;

    state_t                        state_q, state_d;
    logic [LW-1:0]                 layer_q, layer_d;
    logic [IW-1:0]                 k_q, k_d;
    logic signed [ACC_W-1:0]       acc_q [N];
    logic signed [ACC_W-1:0]       acc_d [N];
    logic signed [WIDTH-1:0]       act_q [N];
    logic signed [WIDTH-1:0]       act_d [N];
    logic signed [WIDTH-1:0]       w_q [M][N][N+1];
    logic signed [WIDTH-1:0]       w_d [M][N][N+1];
    logic [N-1:0][WIDTH-1:0]       out_q, out_d;
    logic                          eoc_q, eoc_d;

    logic                          busy;
    logic                          relu_en;
    logic signed [WIDTH-1:0]       a_k;
    logic signed [WIDTH-1:0]       lane_w    [N];
    logic signed [2*WIDTH-1:0]     lane_prod [N];
    logic signed [ACC_W-1:0]       lane_sh   [N];
    logic signed [WIDTH-1:0]       lane_res  [N];

    assign busy     = (state_q == S_MAC) || (state_q == S_WB);
    assign relu_en  = (layer_q != LAST_LAYER) || (OUT_ACT != 0);
    assign bus.out  = out_q;
    assign bus.eoc  = eoc_q;
    assign bus.busy = busy;

    // Per-lane datapath: the bias term multiplies by 1.0, i.e. a shift by FRAC.
    always_comb begin
        a_k = '0;
        for (int i = 0; i < N; i++) begin
            if (k_q == IW'(i)) a_k = act_q[i];
        end
        for (int j = 0; j < N; j++) begin
            lane_w[j] = w_q[layer_q][j][k_q];
            if (k_q == K_BIAS) lane_prod[j] = (2*WIDTH)'(lane_w[j]) <<< FRAC;
            else               lane_prod[j] = (2*WIDTH)'(lane_w[j]) * (2*WIDTH)'(a_k);
            lane_sh[j] = acc_q[j] >>> FRAC;
            if (lane_sh[j] > MAX_A)      lane_res[j] = MAX_W;
            else if (lane_sh[j] < MIN_A) lane_res[j] = MIN_W;
            else                         lane_res[j] = lane_sh[j][WIDTH-1:0];
            if (relu_en && lane_res[j][WIDTH-1]) lane_res[j] = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        k_d     = k_q;
        acc_d   = acc_q;
        act_d   = act_q;
        w_d     = w_q;
        out_d   = out_q;
        eoc_d   = 1'b0;

        // Writes land before a same-edge start, so that run sees them.
        if (bus.w_we && !busy && bus.w_layer <= LAST_LAYER &&
            bus.w_neuron <= LAST_NEUR && bus.w_idx <= K_BIAS) begin
            w_d[bus.w_layer][bus.w_neuron][bus.w_idx] = bus.w_data;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.soc) begin
                    for (int i = 0; i < N; i++) begin
                        act_d[i] = bus.in[i];
                        acc_d[i] = '0;
                    end
                    layer_d = '0;
                    k_d     = '0;
                    state_d = S_MAC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MAC: begin
                for (int j = 0; j < N; j++) begin
                    acc_d[j] = acc_q[j] + ACC_W'(lane_prod[j]);
                end
                if (k_q == K_BIAS) begin
                    k_d     = '0;
                    state_d = S_WB;
                end else begin
                    k_d = k_q + IW'(1);
                end
            end
            S_WB: begin
                if (layer_q == LAST_LAYER) begin
                    for (int j = 0; j < N; j++) out_d[j] = lane_res[j];
                    eoc_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    for (int j = 0; j < N; j++) begin
                        act_d[j] = lane_res[j];
                        acc_d[j] = '0;
                    end
                    layer_d = layer_q + LW'(1);
                    k_d     = '0;
                    state_d = S_MAC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            layer_q <= '0;
            k_q     <= '0;
            out_q   <= '0;
            eoc_q   <= 1'b0;
            for (int j = 0; j < N; j++) begin
                acc_q[j] <= '0;
                act_q[j] <= '0;
            end
            for (int l = 0; l < M; l++)
                for (int j = 0; j < N; j++)
                    for (int i = 0; i <= N; i++)
                        w_q[l][j][i] <= '0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            k_q     <= k_d;
            out_q   <= out_d;
            eoc_q   <= eoc_d;
            acc_q   <= acc_d;
            act_q   <= act_d;
            w_q     <= w_d;
        end
    end
endmodule

// File: tb/tb_mlp_folded_engine.sv
// tb/tb_mlp_folded_engine.sv - scoreboard bench for mlp_folded_engine (ReLU and linear output instances)
module tb_mlp_folded_engine;
    localparam int N    = 5;
    localparam int M    = 3;
    localparam int W    = 8;
    localparam int FRAC = 4;
    localparam int LAT  = M * (N + 2);

    typedef logic [N-1:0][W-1:0] vec_t;
    typedef struct {
        vec_t e1;
        vec_t e0;
        int   at_cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   nvec;
    int   nerr;
    int   wm [M][N][N+1];
    exp_t sb_q [$];

    mlp_folded_engine_if #(.N(N), .M(M), .WIDTH(W)) bus1 ();
    mlp_folded_engine_if #(.N(N), .M(M), .WIDTH(W)) bus0 ();

    mlp_folded_engine #(.N(N), .M(M), .WIDTH(W), .FRAC(FRAC), .OUT_ACT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );
    mlp_folded_engine #(.N(N), .M(M), .WIDTH(W), .FRAC(FRAC), .OUT_ACT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic vec_t pack5(input int v0, input int v1, input int v2, input int v3, input int v4);
        vec_t v;
        v[0] = W'(v0); v[1] = W'(v1); v[2] = W'(v2); v[3] = W'(v3); v[4] = W'(v4);
        return v;
    endfunction

    function automatic vec_t fill(input int v);
        vec_t r;
        for (int i = 0; i < N; i++) r[i] = W'(v);
        return r;
    endfunction

    function automatic vec_t model(input vec_t x, input bit linear_out);
        longint a [N];
        longint r [N];
        longint acc, s;
        vec_t   res;
        for (int i = 0; i < N; i++) a[i] = longint'($signed(x[i]));
        for (int l = 0; l < M; l++) begin
            for (int j = 0; j < N; j++) begin
                acc = longint'(wm[l][j][N]) * (longint'(1) << FRAC);
                for (int k = 0; k < N; k++) acc += longint'(wm[l][j][k]) * a[k];
                s = acc >>> FRAC;
                if (s > 127)  s = 127;
                if (s < -128) s = -128;
                if (s < 0 && !(linear_out && l == M - 1)) s = 0;
                r[j] = s;
            end
            for (int j = 0; j < N; j++) a[j] = r[j];
        end
        for (int j = 0; j < N; j++) res[j] = W'(a[j]);
        return res;
    endfunction

    task automatic drive(input vec_t x, input bit s);
        bus1.soc = s; bus1.in = x;
        bus0.soc = s; bus0.in = x;
    endtask

    task automatic wr(input int l, input int n, input int i, input int d, input bit accept);
        @(negedge clk);
        bus1.w_we = 1'b1; bus1.w_layer = l[1:0]; bus1.w_neuron = n[2:0]; bus1.w_idx = i[2:0]; bus1.w_data = d[7:0];
        bus0.w_we = 1'b1; bus0.w_layer = l[1:0]; bus0.w_neuron = n[2:0]; bus0.w_idx = i[2:0]; bus0.w_data = d[7:0];
        if (accept) wm[l][n][i] = d;
        @(negedge clk);
        bus1.w_we = 1'b0;
        bus0.w_we = 1'b0;
    endtask

    task automatic load_all(input int wdiag, input int woff, input int wbias);
        for (int l = 0; l < M; l++)
            for (int j = 0; j < N; j++)
                for (int i = 0; i <= N; i++)
                    wr(l, j, i, (i == N) ? wbias : ((i == j) ? wdiag : woff), 1'b1);
    endtask

    task automatic start(input vec_t x);
        exp_t e;
        @(negedge clk);
        drive(x, 1'b1);
        e.e1 = model(x, 1'b0);
        e.e0 = model(x, 1'b1);
        e.at_cyc = cyc + 1 + LAT;
        sb_q.push_back(e);
        @(negedge clk);
        drive(x, 1'b0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            chk("timeout", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (sb_q.size() != 0 && !bus1.eoc && cyc > sb_q[0].at_cyc) begin
                chk("eoc_missing", 64'(cyc), 64'(sb_q[0].at_cyc));
                void'(sb_q.pop_front());
            end else if (bus1.eoc) begin
                if (sb_q.size() == 0) begin
                    chk("eoc_spurious", 64'(bus1.eoc), 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("eoc_cycle", 64'(cyc), 64'(e.at_cyc));
                    chk("out_relu", 64'(bus1.out), 64'(e.e1));
                    chk("eoc_lin", 64'(bus0.eoc), 64'd1);
                    chk("out_lin", 64'(bus0.out), 64'(e.e0));
                end
            end
        end
    end

    initial begin
        vec_t x_id, x1, x2;
        int   s;
        cyc = 0; nvec = 0; nerr = 0;
        for (int l = 0; l < M; l++)
            for (int j = 0; j < N; j++)
                for (int i = 0; i <= N; i++)
                    wm[l][j][i] = 0;
        rst_n = 1'b0;
        drive('0, 1'b0);
        bus1.w_we = 1'b0; bus1.w_layer = '0; bus1.w_neuron = '0; bus1.w_idx = '0; bus1.w_data = '0;
        bus0.w_we = 1'b0; bus0.w_layer = '0; bus0.w_neuron = '0; bus0.w_idx = '0; bus0.w_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_out", 64'(bus1.out), 64'd0);
        chk("rst_eoc", 64'(bus1.eoc), 64'd0);
        chk("rst_busy", 64'(bus1.busy), 64'd0);

        drive('0, 1'b1);
        @(negedge clk);
        drive('0, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("soc_in_reset_busy", 64'(bus1.busy), 64'd0);

        x_id = pack5(10, 20, -5, 30, 7);
        load_all(16, 0, 0);
        start(x_id);
        chk("busy_after_start", 64'(bus1.busy), 64'd1);
        wait_done();
        chk("ident_const", 64'(bus1.out), 64'(pack5(10, 20, 0, 30, 7)));
        chk("ident_lin_const", 64'(bus0.out), 64'(pack5(10, 20, 0, 30, 7)));
        chk("busy_after_done", 64'(bus1.busy), 64'd0);

        start(x_id);
        repeat (3) @(negedge clk);
        wr(0, 0, 0, 100, 1'b0);
        wait_done();
        wr(0, 0, 7, 100, 1'b0);
        wr(3, 0, 0, 100, 1'b0);
        wr(0, 7, 0, 100, 1'b0);
        start(x_id);
        wait_done();
        chk("guard_const", 64'(bus1.out), 64'(pack5(10, 20, 0, 30, 7)));

        load_all(0, 0, 16);
        start(pack5(-100, 3, 55, -1, 127));
        wait_done();
        chk("bias_const", 64'(bus1.out), 64'(fill(16)));

        load_all(127, 127, 127);
        start(fill(127));
        wait_done();
        chk("sat_hi_const", 64'(bus1.out), 64'(fill(127)));
        start(fill(-128));
        wait_done();

        for (int l = 0; l < M; l++)
            for (int j = 0; j < N; j++)
                for (int i = 0; i <= N; i++)
                    wr(l, j, i, $urandom_range(0, 255) - 128, 1'b1);
        for (int t = 0; t < 4; t++) begin
            vec_t xr;
            for (int i = 0; i < N; i++) xr[i] = W'($urandom_range(0, 255));
            start(xr);
            wait_done();
        end

        load_all(16, 0, 0);
        x1 = pack5(1, 2, 3, 4, 5);
        x2 = pack5(9, -9, 60, 0, 100);
        start(x1);
        s = cyc;
        while (cyc < s + 20) @(negedge clk);
        begin
            exp_t e;
            drive(x2, 1'b1);
            e.e1 = model(x2, 1'b0);
            e.e0 = model(x2, 1'b1);
            e.at_cyc = s + 22 + LAT;
            sb_q.push_back(e);
        end
        repeat (2) @(negedge clk);
        drive(x2, 1'b0);
        while (cyc < s + 30) @(negedge clk);
        chk("b2b_hold", 64'(bus1.out), 64'(pack5(1, 2, 3, 4, 5)));
        chk("b2b_busy", 64'(bus1.busy), 64'd1);
        wait_done();
        chk("b2b_second", 64'(bus1.out), 64'(pack5(9, 0, 60, 0, 100)));

        start(x_id);
        s = cyc;
        while (cyc < s + 9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out", 64'(bus1.out), 64'd0);
        chk("midrst_eoc", 64'(bus1.eoc), 64'd0);
        chk("midrst_busy", 64'(bus1.busy), 64'd0);
        sb_q.delete();
        for (int l = 0; l < M; l++)
            for (int j = 0; j < N; j++)
                for (int i = 0; i <= N; i++)
                    wm[l][j][i] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start(x_id);
        wait_done();
        chk("rerun_zero", 64'(bus1.out), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
